// File: rtl/count_zero_seq_if.sv
// count_zero_seq_if: handshake bundle for the trailing-zero counter.
//   i_valid/i_ready/i_data : word input handshake (upstream -> block)
//   o_valid/o_ready        : result handshake (block -> downstream)
//   o_cnt                  : zeros below the lowest set bit, 0..DATA_W
//   o_zero                 : scanned word was all zeros
// master: the side that drives words in and accepts results.
// slave : the counter itself.
interface count_zero_seq_if #(
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              i_valid;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              o_ready;
  logic [CNT_W-1:0]  o_cnt;
  logic              o_zero;

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_cnt, o_zero
  );

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_cnt, o_zero
  );
endinterface

// File: rtl/count_zero_seq.sv
// count_zero_seq: multi-cycle trailing-zero counter.
// Accepts a DATA_W-bit word, scans it one nibble per cycle from bit 0 and
// reports the number of zeros below the lowest set bit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : count_zero_seq_if.slave (word in, result out)
// Latency from accept is (index of first nonzero nibble + 1) cycles.
module count_zero_seq #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  count_zero_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx;
  logic              zero_q;

  logic [2:0]        tz;
  logic              nib_nz;
  logic              last_nib;
  logic [CNT_W-1:0]  sum;

  // Per-nibble trailing-zero count of the current low nibble.
  always_comb begin
    tz = 3'd4;
    casez (shreg[3:0])
      4'b???1: tz = 3'd0;
      4'b??10: tz = 3'd1;
      4'b?100: tz = 3'd2;
      4'b1000: tz = 3'd3;
      default: tz = 3'd4;
    endcase
  end

  assign nib_nz   = |shreg[3:0];
  assign last_nib = (idx == IDX_W'(NIB - 1));
  assign sum      = total + CNT_W'(tz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.i_valid)             state_nx = SCAN;
      SCAN: if (nib_nz || last_nib)      state_nx = DONE;
      DONE: if (bus.o_ready)             state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Datapath: result registers are only written on scan completion, so they
  // stay frozen through DONE and keep their value after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      total  <= '0;
      idx    <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            shreg <= bus.i_data;
            total <= '0;
            idx   <= '0;
          end
        end
        SCAN: begin
          total <= sum;
          if (nib_nz) begin
            cnt_q  <= sum;
            zero_q <= 1'b0;
          end else if (last_nib) begin
            cnt_q  <= CNT_W'(DATA_W);
            zero_q <= 1'b1;
          end else begin
            shreg <= shreg >> 4;
            idx   <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.i_ready = (state == IDLE);
  assign bus.o_valid = (state == DONE);
  assign bus.o_cnt   = cnt_q;
  assign bus.o_zero  = zero_q;

endmodule

// File: tb/tb_count_zero_seq.sv
module tb_count_zero_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  count_zero_seq_if #(.DATA_W(32)) bus_if ();

  count_zero_seq #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one word with o_ready=1, measure latency, check result and
  // the single-cycle o_valid pulse.
  task automatic run_word(input string tag, input logic [31:0] data,
                          input int exp_cnt, input bit exp_zero, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_irdy"}, bus_if.i_ready, 1);
    bus_if.i_valid = 1'b1;
    bus_if.i_data  = data;
    bus_if.o_ready = 1'b1;
    @(negedge clk);
    bus_if.i_valid = 1'b0;
    bus_if.i_data  = ~data;
    lat = 0;
    while (!bus_if.o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_cnt"}, bus_if.o_cnt, exp_cnt);
    check({tag, "_zero"}, bus_if.o_zero, exp_zero);
    @(negedge clk);
    check({tag, "_vdrop"}, bus_if.o_valid, 0);
    check({tag, "_irdy2"}, bus_if.i_ready, 1);
    check({tag, "_cnthold"}, bus_if.o_cnt, exp_cnt);
  endtask

  initial begin
    int lat;
    int acc;
    int nres;
    int budget;
    bit seen_valid;
    logic [31:0] words [3];
    int          res_cnt [3];
    logic        res_zero [3];

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus_if.i_valid = 1'b0;
    bus_if.i_data  = '0;
    bus_if.o_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_irdy", bus_if.i_ready, 1);
    check("rst_oval", bus_if.o_valid, 0);
    check("rst_cnt", bus_if.o_cnt, 0);
    check("rst_zero", bus_if.o_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_irdy", bus_if.i_ready, 1);
    check("post_rst_oval", bus_if.o_valid, 0);

    run_word("w1", 32'h0000_0001, 0, 1'b0, 1);
    run_word("w100", 32'h0000_0100, 8, 1'b0, 3);
    run_word("w8000", 32'h8000_0000, 31, 1'b0, 8);
    run_word("w0", 32'h0000_0000, 32, 1'b1, 8);

    // Backpressure
    @(negedge clk);
    bus_if.i_valid = 1'b1;
    bus_if.i_data  = 32'h0000_0040;
    bus_if.o_ready = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!bus_if.o_valid && lat < 20) begin
      bus_if.i_data = ~bus_if.i_data;
      @(negedge clk);
      lat++;
    end
    check("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      bus_if.i_data = (i % 2 == 0) ? 32'h0000_0001 : 32'hFFFF_0000;
      @(negedge clk);
      check("bp_oval", bus_if.o_valid, 1);
      check("bp_cnt", bus_if.o_cnt, 6);
      check("bp_irdy", bus_if.i_ready, 0);
    end
    bus_if.i_valid = 1'b0;
    bus_if.o_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_irdy", bus_if.i_ready, 1);
    check("bp_rel_oval", bus_if.o_valid, 0);
    check("bp_rel_cnt", bus_if.o_cnt, 6);

    // Reset mid-scan
    @(negedge clk);
    bus_if.i_valid = 1'b1;
    bus_if.i_data  = 32'h0;
    @(negedge clk);
    bus_if.i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ars_irdy", bus_if.i_ready, 1);
    check("ars_oval", bus_if.o_valid, 0);
    check("ars_cnt", bus_if.o_cnt, 0);
    check("ars_zero", bus_if.o_zero, 0);
    seen_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus_if.o_valid) seen_valid = 1'b1;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.o_valid) seen_valid = 1'b1;
    end
    check("ars_no_valid", seen_valid, 0);
    run_word("w2", 32'h0000_0002, 1, 1'b0, 1);

    // Back-to-back with i_valid held
    words[0] = 32'h10;
    words[1] = 32'h0;
    words[2] = 32'h3;
    acc = 0;
    nres = 0;
    budget = 0;
    bus_if.o_ready = 1'b1;
    while (nres < 3 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (bus_if.o_valid) begin
        res_cnt[nres]  = int'(bus_if.o_cnt);
        res_zero[nres] = bus_if.o_zero;
        nres++;
      end
      if (bus_if.i_ready) begin
        if (acc < 3) begin
          bus_if.i_valid = 1'b1;
          bus_if.i_data  = words[acc];
          acc++;
        end else begin
          bus_if.i_valid = 1'b0;
        end
      end else begin
        bus_if.i_data = 32'hFFFF_FFFF;
      end
    end
    bus_if.i_valid = 1'b0;
    check("b2b_nres", nres, 3);
    check("b2b_acc", acc, 3);
    if (nres == 3) begin
      check("b2b_cnt0", res_cnt[0], 4);
      check("b2b_zero0", res_zero[0], 0);
      check("b2b_cnt1", res_cnt[1], 32);
      check("b2b_zero1", res_zero[1], 1);
      check("b2b_cnt2", res_cnt[2], 0);
      check("b2b_zero2", res_zero[2], 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
